// File: rtl/pll_lock_sequencer.sv
// Brings the phi/theta sensor PLLs out of reset, waits for stable lock, then
// releases the TDC reset; recovers from lock loss and retries timeouts on its own.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE    = 64,
    parameter int unsigned LOCK_TIMEOUT   = 4096,
    parameter int unsigned TDC_RST_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic        clear_error,
    input  logic        phi_locked,
    input  logic        theta_locked,
    output logic        reset_phi,
    output logic        reset_theta,
    output logic        tdc_reset,
    output logic        ready,
    output logic        error,
    output logic        busy,
    output logic [31:0] status_export
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_PLL   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_TDC_RST   = 3'd3,
        S_RUN       = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] TDC_LAST     = 16'(TDC_RST_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

    state_t      state, state_nxt;
    logic [1:0]  phi_sync, theta_sync;
    logic        phi_s, theta_s, both_locked;
    logic [15:0] phase, phase_nxt;
    logic [15:0] stab, stab_nxt;
    logic [3:0]  retry_cnt, retry_nxt;
    logic [7:0]  lock_loss_cnt, lock_loss_nxt;

    assign phi_s       = phi_sync[1];
    assign theta_s     = theta_sync[1];
    assign both_locked = phi_s & theta_s;

    always_comb begin
        state_nxt     = state;
        retry_nxt     = retry_cnt;
        lock_loss_nxt = lock_loss_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RST_PLL;
                    retry_nxt = '0;
                end
            end
            S_RST_PLL: begin
                if (phase == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock success is checked first so it wins over a coincident timeout.
                if (both_locked && stab == STABLE_LAST) begin
                    state_nxt = S_TDC_RST;
                end else if (phase == TIMEOUT_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt = retry_cnt + 4'd1;
                        state_nxt = S_RST_PLL;
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_TDC_RST: begin
                if (phase == TDC_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!both_locked) begin
                    state_nxt = S_RST_PLL;
                    retry_nxt = '0;
                    if (lock_loss_cnt != 8'hFF) lock_loss_nxt = lock_loss_cnt + 8'd1;
                end else if (start) begin
                    state_nxt = S_RST_PLL;
                    retry_nxt = '0;
                end
            end
            S_ERROR: begin
                if (clear_error) begin
                    state_nxt = S_IDLE;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        phase_nxt = (state_nxt != state) ? 16'd0 : phase + 16'd1;
        // Any unlocked cycle restarts the stability window.
        stab_nxt  = (state == S_WAIT_LOCK && state_nxt == S_WAIT_LOCK && both_locked)
                    ? stab + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state         <= S_IDLE;
            phi_sync      <= '0;
            theta_sync    <= '0;
            phase         <= '0;
            stab          <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            reset_phi     <= 1'b1;
            reset_theta   <= 1'b1;
            tdc_reset     <= 1'b1;
            ready         <= 1'b0;
            error         <= 1'b0;
            busy          <= 1'b0;
            status_export <= '0;
        end else begin
            phi_sync      <= {phi_sync[0], phi_locked};
            theta_sync    <= {theta_sync[0], theta_locked};
            state         <= state_nxt;
            phase         <= phase_nxt;
            stab          <= stab_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= lock_loss_nxt;
            // Outputs are registered from the next state so they track the state register.
            reset_phi     <= state_nxt inside {S_IDLE, S_RST_PLL, S_ERROR};
            reset_theta   <= state_nxt inside {S_IDLE, S_RST_PLL, S_ERROR};
            tdc_reset     <= state_nxt != S_RUN;
            ready         <= state_nxt == S_RUN;
            error         <= state_nxt == S_ERROR;
            busy          <= state_nxt inside {S_RST_PLL, S_WAIT_LOCK, S_TDC_RST};
            status_export <= {8'h00, lock_loss_nxt, 4'h0, retry_nxt, 2'b00,
                              state_nxt == S_ERROR, state_nxt == S_RUN, 1'b0, state_nxt};
        end
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Hardware sequencer that brings the phi and theta sensor PLLs out of reset, waits for stable lock, and only then releases the TDC sensor reset. It replaces software-timed toggling of the reset/locked PIOs on the Nios V SoC. It sits between the soc_system PIO exports (start/clear/status) and the PLL/TDC reset pins. It also handles lock-loss recovery and bounded retries without CPU involvement.

## Interface
Parameters:
- RST_CYCLES, 16: cycles PLL resets are held per attempt (1..65535)
- LOCK_STABLE, 64: consecutive cycles both locks must be high (1..65535)
- LOCK_TIMEOUT, 4096: max cycles in WAIT_LOCK per attempt (must be > LOCK_STABLE, ≤65535)
- TDC_RST_CYCLES, 8: cycles TDC reset is held after lock (1..65535)
- MAX_RETRIES, 3: extra attempts after a timeout before ERROR (0..15)

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to (re)run the sequence
- clear_error  in  1  single-cycle request to leave ERROR
- phi_locked  in  1  phi PLL lock, asynchronous
- theta_locked  in  1  theta PLL lock, asynchronous
- reset_phi  out  1  phi PLL reset, active-high
- reset_theta  out  1  theta PLL reset, active-high
- tdc_reset  out  1  TDC sensor reset, active-high
- ready  out  1  sequence complete, TDCs running
- error  out  1  retries exhausted
- busy  out  1  sequence in progress
- status_export  out  32  {lock_loss_cnt[7:0] at 23:16, retry_cnt[3:0] at 11:8, error at 5, ready at 4, 1'b0 at 3, state[2:0] at 2:0}; all other bits 0

## Operation
- The lock inputs each pass through a 2-flop synchronizer. All decisions use the synchronized values (phi_s, theta_s).
- States (encoding): IDLE=0, RST_PLL=1, WAIT_LOCK=2, TDC_RST=3, RUN=4, ERROR=5. A single 16-bit phase counter clears on every state entry. A separate 16-bit stability counter is used in WAIT_LOCK.
- Outputs are Moore, decoded from the state register:
  - reset_phi = reset_theta = state ∈ {IDLE, RST_PLL, ERROR}
  - tdc_reset = state ≠ RUN
  - ready = RUN; error = ERROR; busy = state ∈ {RST_PLL, WAIT_LOCK, TDC_RST}
- IDLE: start → RST_PLL; retry_cnt cleared.
- RST_PLL: stays exactly RST_CYCLES cycles, then → WAIT_LOCK.
- WAIT_LOCK:
  - Stability counter increments while phi_s & theta_s, and clears to 0 on any cycle either is low.
  - When it reaches LOCK_STABLE → TDC_RST.
  - Otherwise, after LOCK_TIMEOUT cycles in the state: if retry_cnt < MAX_RETRIES, increment retry_cnt and → RST_PLL; else → ERROR.
  - If lock success and timeout fall in the same cycle, success wins.
- TDC_RST: stays exactly TDC_RST_CYCLES cycles, then → RUN.
- RUN:
  - Either phi_s or theta_s low → RST_PLL, lock_loss_cnt += 1 (saturates at 255), retry_cnt cleared.
  - Otherwise start → RST_PLL, retry_cnt cleared, lock_loss_cnt unchanged.
  - If lock loss and start occur together, lock loss wins and is counted.
- ERROR: holds until clear_error → IDLE with retry_cnt cleared. start is ignored in ERROR, including when it arrives in the same cycle as clear_error.
- start is ignored in RST_PLL, WAIT_LOCK and TDC_RST. clear_error is ignored outside ERROR.
- Lock loss during RST_PLL or TDC_RST is not acted on in that state. A loss during TDC_RST is caught on the first RUN cycle.

## Timing
- Reset (synchronous, any state, mid-sequence included): state IDLE, all counters 0, synchronizers 0. Outputs next cycle: reset_phi=1, reset_theta=1, tdc_reset=1, ready=0, error=0, busy=0, status_export=0.
- Convention: an input sampled at edge of cycle N changes state, and all outputs, in cycle N+1.
- Lock input to decision latency: 2 cycles of synchronizer plus 1 registered transition. A lock edge in cycle N is reflected in the outputs in cycle N+3.
- Nominal run, with locks already stable: start in cycle 0 → RST_PLL in cycles 1..RST_CYCLES → WAIT_LOCK for LOCK_STABLE cycles → TDC_RST for TDC_RST_CYCLES cycles → RUN. Total: 1+RST_CYCLES+LOCK_STABLE+TDC_RST_CYCLES cycles to ready.
- A failed attempt costs RST_CYCLES+LOCK_TIMEOUT cycles.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, TDC_RST_CYCLES=3, MAX_RETRIES=2, with locks high from before start unless stated.
- Nominal: start at cycle 0.
  - reset_phi/theta high in cycles 1–4 and low from cycle 5.
  - tdc_reset high through cycle 15.
  - ready=1, tdc_reset=0, status_export[2:0]=4 from cycle 16.
- Glitchy lock: theta_locked drops for 1 cycle mid WAIT_LOCK. The stability counter restarts, so ready is delayed by exactly (cycles elapsed + 1); no retry.
- Timeout and exhaustion: locks held low.
  - Three attempts of 36 cycles each; retry_cnt reads 1 then 2.
  - error=1, state=5, all resets high from cycle 109.
  - clear_error → IDLE, retry_cnt=0.
- Lock loss in RUN: phi_locked falls at cycle N.
  - In cycle N+3: tdc_reset=1, ready=0, state=1, lock_loss_cnt=1.
  - Ready again 4+8+3 cycles later once the lock is restored.
- Priority: start together with lock loss in RUN → counted once. start together with clear_error in ERROR → IDLE, no sequence started.
- Mid-sequence reset: assert reset_reset in WAIT_LOCK → next cycle state=0, status_export=0, reset_phi=1, reset_theta=1, tdc_reset=1; start then gives the nominal timing.
